// File: rtl/wordle_guess_engine.sv
// wordle_guess_engine
// Wordle game controller. A target word is latched on start_i. Letters, backspace and
// submit are then accepted from the keyboard layer. Each submitted guess is scored
// green/yellow/gray with correct duplicate-letter handling, and win/lose are tracked
// over up to MAX_GUESSES attempts.
//
// Optional build macro: WORDLE_HARD_MODE_EN. When defined, every position that was green
// in an earlier guess of the current game must keep that letter, or the submit is refused.
//
// Ports:
//   clk_i, reset_ni     clock (rising edge), asynchronous active-low reset
//   start_i, ack_i      begin a game from INIT; return from DONE to INIT
//   target_i            secret word, position 0 in bits [LW-1:0], sampled on start_i
//   letter_valid_i      enter letter_in_i at the cursor
//   letter_in_i         letter code, 0..25 = A..Z
//   backspace_i         delete the letter before the cursor
//   submit_i            submit the current guess
//   state_o             INIT=0 ENTRY=1 SCORE_G=2 SCORE_Y=3 CHECK=4 DONE=5
//   guess_num_o         guesses scored so far
//   cursor_o            letters in the current guess
//   guess_word_o        current or last-scored guess
//   score_o             2 bits per position: 00 empty, 01 gray, 10 yellow, 11 green
//   score_valid_o       high during the CHECK cycle
//   reject_o            one-cycle pulse after a refused submit
//   win_o, lose_o       game result, held until the next start
module wordle_guess_engine #(
    parameter int unsigned WORD_LEN    = 5,
    parameter int unsigned MAX_GUESSES = 6,
    parameter int unsigned LW          = 5
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   start_i,
    input  logic                   ack_i,
    input  logic [WORD_LEN*LW-1:0] target_i,
    input  logic                   letter_valid_i,
    input  logic [LW-1:0]          letter_in_i,
    input  logic                   backspace_i,
    input  logic                   submit_i,
    output logic [2:0]             state_o,
    output logic [3:0]             guess_num_o,
    output logic [3:0]             cursor_o,
    output logic [WORD_LEN*LW-1:0] guess_word_o,
    output logic [2*WORD_LEN-1:0]  score_o,
    output logic                   score_valid_o,
    output logic                   reject_o,
    output logic                   win_o,
    output logic                   lose_o
);

    localparam int unsigned WordW    = WORD_LEN * LW;
    localparam logic [3:0]  LastIdx  = 4'(WORD_LEN - 1);
    localparam logic [3:0]  FullCur  = 4'(WORD_LEN);
    localparam logic [3:0]  MaxGuess = 4'(MAX_GUESSES);

    typedef enum logic [2:0] {
        StInit   = 3'd0,
        StEntry  = 3'd1,
        StScoreG = 3'd2,
        StScoreY = 3'd3,
        StCheck  = 3'd4,
        StDone   = 3'd5
    } state_e;

    state_e                state_q;
    logic [WordW-1:0]      target_q;
    logic [WordW-1:0]      guess_q;
    logic [2*WORD_LEN-1:0] score_q;
    logic [WORD_LEN-1:0]   used_q;
    logic [3:0]            idx_q;
    logic [3:0]            cursor_q;
    logic [3:0]            guess_num_q;
    logic                  score_valid_q;
    logic                  reject_q;
    logic                  win_q;
    logic                  lose_q;

    logic [WORD_LEN-1:0]   green;
    logic [2*WORD_LEN-1:0] green_score;
    logic [WORD_LEN-1:0]   yellow_hit;
    logic [LW-1:0]         cur_letter;
    logic [WordW-1:0]      word_ins;
    logic                  letter_ok;
    logic                  submit_bad;

    always_comb begin
        green       = '0;
        green_score = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            green[i]              = (guess_q[i*LW +: LW] == target_q[i*LW +: LW]);
            green_score[2*i +: 2] = green[i] ? 2'b11 : 2'b00;
        end
    end

    // Lowest target slot not yet consumed that holds the letter under scrutiny.
    always_comb begin
        cur_letter = guess_q[idx_q*LW +: LW];
        yellow_hit = '0;
        for (int j = WORD_LEN - 1; j >= 0; j--) begin
            if (!used_q[j] && (target_q[j*LW +: LW] == cur_letter)) begin
                yellow_hit    = '0;
                yellow_hit[j] = 1'b1;
            end
        end
    end

    // The first letter after a scored guess starts from an empty word.
    always_comb begin
        word_ins                       = (cursor_q == 4'd0) ? '0 : guess_q;
        word_ins[cursor_q*LW +: LW]    = letter_in_i;
    end

    assign letter_ok = (32'(letter_in_i) < 32'd26);

`ifdef WORDLE_HARD_MODE_EN
    logic [WORD_LEN-1:0] hist_q;
    assign submit_bad = |(hist_q & ~green);
`else
    assign submit_bad = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= StInit;
            target_q      <= '0;
            guess_q       <= '0;
            score_q       <= '0;
            used_q        <= '0;
            idx_q         <= '0;
            cursor_q      <= '0;
            guess_num_q   <= '0;
            score_valid_q <= 1'b0;
            reject_q      <= 1'b0;
            win_q         <= 1'b0;
            lose_q        <= 1'b0;
`ifdef WORDLE_HARD_MODE_EN
            hist_q        <= '0;
`endif
        end else begin
            score_valid_q <= 1'b0;
            reject_q      <= 1'b0;
            case (state_q)
                StInit: begin
`ifdef WORDLE_HARD_MODE_EN
                    hist_q <= '0;
`endif
                    if (start_i) begin
                        target_q    <= target_i;
                        guess_num_q <= '0;
                        cursor_q    <= '0;
                        guess_q     <= '0;
                        score_q     <= '0;
                        win_q       <= 1'b0;
                        lose_q      <= 1'b0;
                        state_q     <= StEntry;
                    end
                end
                StEntry: begin
                    if (submit_i) begin
                        if ((cursor_q != FullCur) || submit_bad) begin
                            reject_q <= 1'b1;
                        end else begin
                            score_q <= '0;
                            state_q <= StScoreG;
                        end
                    end else if (backspace_i) begin
                        if (cursor_q != 4'd0) begin
                            cursor_q                          <= cursor_q - 4'd1;
                            guess_q[(cursor_q-4'd1)*LW +: LW] <= '0;
                        end
                    end else if (letter_valid_i && (cursor_q != FullCur) && letter_ok) begin
                        guess_q  <= word_ins;
                        cursor_q <= cursor_q + 4'd1;
                    end
                end
                StScoreG: begin
                    score_q <= green_score;
                    used_q  <= green;
                    idx_q   <= '0;
                    state_q <= StScoreY;
                end
                StScoreY: begin
                    if (score_q[idx_q*2 +: 2] != 2'b11) begin
                        if (|yellow_hit) begin
                            used_q                 <= used_q | yellow_hit;
                            score_q[idx_q*2 +: 2]  <= 2'b10;
                        end else begin
                            score_q[idx_q*2 +: 2]  <= 2'b01;
                        end
                    end
                    if (idx_q == LastIdx) begin
                        score_valid_q <= 1'b1;
                        state_q       <= StCheck;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                StCheck: begin
                    guess_num_q <= guess_num_q + 4'd1;
`ifdef WORDLE_HARD_MODE_EN
                    hist_q <= hist_q | green;
`endif
                    if (&score_q) begin
                        win_q   <= 1'b1;
                        state_q <= StDone;
                    end else if ((guess_num_q + 4'd1) == MaxGuess) begin
                        lose_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cursor_q <= '0;
                        state_q  <= StEntry;
                    end
                end
                StDone: begin
                    if (ack_i) begin
                        state_q <= StInit;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign state_o       = state_q;
    assign guess_num_o   = guess_num_q;
    assign cursor_o      = cursor_q;
    assign guess_word_o  = guess_q;
    assign score_o       = score_q;
    assign score_valid_o = score_valid_q;
    assign reject_o      = reject_q;
    assign win_o         = win_q;
    assign lose_o        = lose_q;

endmodule
